// File: rtl/decode_pipe_if.sv
// Fetch/writeback/execute-facing bundle of the decode stage.
// The slave modport is the decode stage's view; master is the surrounding datapath.
interface decode_pipe_if #(
    parameter int DATA_W = 16
);
    logic              if_valid;
    logic [15:0]       if_instr;
    logic [DATA_W-1:0] if_pc2;
    logic              if_ready;
    logic              ex_ready;
    logic              flush;
    logic              wb_en;
    logic [2:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              id_valid;
    logic [15:0]       id_instr;
    logic [DATA_W-1:0] id_pc2;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm5;
    logic [DATA_W-1:0] id_imm8;
    logic [DATA_W-1:0] id_imm11;
    logic [2:0]        id_wreg;
    logic              id_wen;
    logic [21:0]       id_ctrl;
    logic              id_halt;

    modport slave (
        input  if_valid, if_instr, if_pc2, ex_ready, flush, wb_en, wb_reg, wb_data,
        output if_ready, id_valid, id_instr, id_pc2, id_rdata1, id_rdata2,
               id_imm5, id_imm8, id_imm11, id_wreg, id_wen, id_ctrl, id_halt
    );

    modport master (
        output if_valid, if_instr, if_pc2, ex_ready, flush, wb_en, wb_reg, wb_data,
        input  if_ready, id_valid, id_instr, id_pc2, id_rdata1, id_rdata2,
               id_imm5, id_imm8, id_imm11, id_wreg, id_wen, id_ctrl, id_halt
    );
endinterface

// File: rtl/decode_pipe.sv
// WISC decode stage: register file, instruction decode, ID/EX register; 1-cycle accept-to-output.
// Backpressure: if_ready drops on ex_ready low with a live slot, load-use hazard, flush or halt.
module decode_pipe #(
    parameter int DATA_W    = 16,
    parameter int BYPASS    = 1,
    parameter int HAZARD_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    decode_pipe_if.slave bus
);
    typedef struct packed {
        logic [2:0] rd_src;
        logic [2:0] a_src1;
        logic [2:0] a_src2;
        logic [2:0] op;
        logic       mem_en;
        logic       mem_wr;
        logic       branch;
        logic       jump;
        logic       exception;
        logic       cin;
        logic       inv_a;
        logic       inv_b;
        logic       sign;
        logic       dump;
    } ctrl_t;

    localparam logic [2:0] RD_MEM   = 3'd1, RD_PC2 = 3'd2, RD_FLAG = 3'd5;
    localparam logic [2:0] RD_CARRY = 3'd6, RD_REV = 3'd7;
    localparam logic [2:0] A1_PC2   = 3'd2, A1_ZERO = 3'd3, A1_RS_SHL8 = 3'd4;
    localparam logic [2:0] A2_IMM5  = 3'd1, A2_IMM8 = 3'd2, A2_IMM11 = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd0, OP_AND = 3'd1, OP_OR = 3'd2, OP_XOR = 3'd3;

    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] rf_d [8];
    logic              valid_q, valid_d, halt_q, halt_d, wen_q, wen_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] pc2_q, pc2_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic [DATA_W-1:0] imm5_q, imm5_d, imm8_q, imm8_d, imm11_q, imm11_d;
    logic [2:0]        wreg_q, wreg_d;
    ctrl_t             ctrl_q, ctrl_d;

    ctrl_t             dec_c;
    logic              dec_wen;
    logic [1:0]        dec_rdst;
    logic [2:0]        dec_wreg, rs, rt;
    logic [DATA_W-1:0] rd1, rd2;
    logic              hazard, if_ready, accept;

    assign rs = bus.if_instr[10:8];
    assign rt = bus.if_instr[7:5];

    always_comb begin
        rd1 = rf_q[rs];
        rd2 = rf_q[rt];
        if (BYPASS != 0 && bus.wb_en && bus.wb_reg == rs) rd1 = bus.wb_data;
        if (BYPASS != 0 && bus.wb_en && bus.wb_reg == rt) rd2 = bus.wb_data;
    end

    always_comb begin
        dec_c      = '0;
        dec_c.sign = 1'b1;
        dec_c.op   = OP_ADD;
        dec_wen    = 1'b0;
        dec_rdst   = 2'd0;
        casez (bus.if_instr[15:11])
            5'b00000: dec_c.dump = 1'b1;
            5'b00001: ;
            5'b00010: dec_c.exception = 1'b1;
            5'b00011: dec_c.jump = 1'b1;
            5'b001??: begin
                // bit 11 selects register-relative (JR/JALR), bit 12 selects link
                dec_c.jump   = 1'b1;
                dec_c.a_src1 = bus.if_instr[11] ? 3'd0 : A1_PC2;
                dec_c.a_src2 = bus.if_instr[11] ? A2_IMM8 : A2_IMM11;
                if (bus.if_instr[12]) begin
                    dec_c.rd_src = RD_PC2;
                    dec_wen      = 1'b1;
                    dec_rdst     = 2'd3;
                end
            end
            5'b0100?: begin
                dec_c.a_src2 = A2_IMM5;
                dec_c.inv_a  = bus.if_instr[11];
                dec_c.cin    = bus.if_instr[11];
                dec_wen      = 1'b1;
                dec_rdst     = 2'd1;
            end
            5'b01010: begin
                dec_c.a_src2 = A2_IMM5;
                dec_c.op     = OP_XOR;
                dec_c.sign   = 1'b0;
                dec_wen      = 1'b1;
                dec_rdst     = 2'd1;
            end
            5'b01011: begin
                dec_c.a_src2 = A2_IMM5;
                dec_c.op     = OP_AND;
                dec_c.inv_b  = 1'b1;
                dec_c.sign   = 1'b0;
                dec_wen      = 1'b1;
                dec_rdst     = 2'd1;
            end
            5'b011??: begin
                dec_c.branch = 1'b1;
                dec_c.a_src1 = A1_PC2;
                dec_c.a_src2 = A2_IMM8;
            end
            5'b10000: begin
                dec_c.mem_en = 1'b1;
                dec_c.mem_wr = 1'b1;
                dec_c.a_src2 = A2_IMM5;
            end
            5'b10001: begin
                dec_c.mem_en = 1'b1;
                dec_c.a_src2 = A2_IMM5;
                dec_c.rd_src = RD_MEM;
                dec_wen      = 1'b1;
                dec_rdst     = 2'd1;
            end
            5'b10010: begin
                dec_c.a_src1 = A1_RS_SHL8;
                dec_c.a_src2 = A2_IMM8;
                dec_c.op     = OP_OR;
                dec_c.sign   = 1'b0;
                dec_wen      = 1'b1;
                dec_rdst     = 2'd2;
            end
            5'b10011: begin
                dec_c.mem_en = 1'b1;
                dec_c.mem_wr = 1'b1;
                dec_c.a_src2 = A2_IMM5;
                dec_wen      = 1'b1;
                dec_rdst     = 2'd2;
            end
            5'b101??: begin
                dec_c.op     = {1'b1, bus.if_instr[12:11]};
                dec_c.a_src2 = A2_IMM5;
                dec_wen      = 1'b1;
                dec_rdst     = 2'd1;
            end
            5'b11000: begin
                dec_c.a_src1 = A1_ZERO;
                dec_c.a_src2 = A2_IMM8;
                dec_wen      = 1'b1;
                dec_rdst     = 2'd2;
            end
            5'b11001: begin
                dec_c.rd_src = RD_REV;
                dec_wen      = 1'b1;
            end
            5'b11010: begin
                dec_c.op = {1'b1, bus.if_instr[1:0]};
                dec_wen  = 1'b1;
            end
            5'b11011: begin
                dec_wen = 1'b1;
                case (bus.if_instr[1:0])
                    2'b00: dec_c.op = OP_ADD;
                    2'b01: begin dec_c.inv_a = 1'b1; dec_c.cin = 1'b1; end
                    2'b10: dec_c.op = OP_XOR;
                    default: begin dec_c.op = OP_AND; dec_c.inv_b = 1'b1; end
                endcase
            end
            5'b111??: begin
                // SEQ/SLT/SLE compare via rs - rt; SCO takes the carry of rs + rt
                dec_c.rd_src = (bus.if_instr[12:11] == 2'b11) ? RD_CARRY : RD_FLAG;
                dec_c.inv_b  = (bus.if_instr[12:11] != 2'b11);
                dec_c.cin    = (bus.if_instr[12:11] != 2'b11);
                dec_wen      = 1'b1;
            end
            default: dec_c.exception = 1'b1;
        endcase
    end

    always_comb begin
        case (dec_rdst)
            2'd0:    dec_wreg = bus.if_instr[4:2];
            2'd1:    dec_wreg = bus.if_instr[7:5];
            2'd2:    dec_wreg = bus.if_instr[10:8];
            default: dec_wreg = 3'd7;
        endcase
    end

    // Conservative: both source fields compared whether or not the instruction reads them
    assign hazard = (HAZARD_EN != 0) && valid_q && ctrl_q.mem_en && !ctrl_q.mem_wr && wen_q &&
                    bus.if_valid && (wreg_q == rs || wreg_q == rt);
    assign if_ready = (bus.ex_ready || !valid_q) && !hazard && !bus.flush && !halt_q;
    assign accept   = bus.if_valid && if_ready;

    always_comb begin
        rf_d = rf_q;
        if (bus.wb_en) rf_d[bus.wb_reg] = bus.wb_data;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc2_d    = pc2_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm5_d   = imm5_q;
        imm8_d   = imm8_q;
        imm11_d  = imm11_q;
        wreg_d   = wreg_q;
        wen_d    = wen_q;
        ctrl_d   = ctrl_q;
        halt_d   = halt_q || (accept && dec_c.dump);
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (hazard && bus.ex_ready) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            instr_d  = bus.if_instr;
            pc2_d    = bus.if_pc2;
            rdata1_d = rd1;
            rdata2_d = rd2;
            imm5_d   = dec_c.sign ? {{(DATA_W-5){bus.if_instr[4]}}, bus.if_instr[4:0]}
                                  : {{(DATA_W-5){1'b0}}, bus.if_instr[4:0]};
            imm8_d   = dec_c.sign ? {{(DATA_W-8){bus.if_instr[7]}}, bus.if_instr[7:0]}
                                  : {{(DATA_W-8){1'b0}}, bus.if_instr[7:0]};
            imm11_d  = dec_c.sign ? {{(DATA_W-11){bus.if_instr[10]}}, bus.if_instr[10:0]}
                                  : {{(DATA_W-11){1'b0}}, bus.if_instr[10:0]};
            wreg_d   = dec_wreg;
            wen_d    = dec_wen;
            ctrl_d   = dec_c;
        end else if (bus.ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
            instr_q  <= '0;
            pc2_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm5_q   <= '0;
            imm8_q   <= '0;
            imm11_q  <= '0;
            wreg_q   <= '0;
            wen_q    <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            rf_q     <= rf_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
            instr_q  <= instr_d;
            pc2_q    <= pc2_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm5_q   <= imm5_d;
            imm8_q   <= imm8_d;
            imm11_q  <= imm11_d;
            wreg_q   <= wreg_d;
            wen_q    <= wen_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign bus.if_ready  = if_ready;
    assign bus.id_valid  = valid_q;
    assign bus.id_instr  = instr_q;
    assign bus.id_pc2    = pc2_q;
    assign bus.id_rdata1 = rdata1_q;
    assign bus.id_rdata2 = rdata2_q;
    assign bus.id_imm5   = imm5_q;
    assign bus.id_imm8   = imm8_q;
    assign bus.id_imm11  = imm11_q;
    assign bus.id_wreg   = wreg_q;
    assign bus.id_wen    = wen_q;
    assign bus.id_ctrl   = ctrl_q;
    assign bus.id_halt   = halt_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: vector table plus hand-written pipeline sequences.
// Variant instances with BYPASS=0 and HAZARD_EN=0 share the main instance's inputs.
module tb_decode_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_pipe_if #(.DATA_W(16)) bus ();
    decode_pipe_if #(.DATA_W(16)) bus_nb ();
    decode_pipe_if #(.DATA_W(16)) bus_nh ();

    decode_pipe #(.DATA_W(16), .BYPASS(1), .HAZARD_EN(1)) dut    (.clk(clk), .rst(rst), .bus(bus));
    decode_pipe #(.DATA_W(16), .BYPASS(0), .HAZARD_EN(1)) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));
    decode_pipe #(.DATA_W(16), .BYPASS(1), .HAZARD_EN(0)) dut_nh (.clk(clk), .rst(rst), .bus(bus_nh));

    assign bus_nb.if_valid = bus.if_valid;  assign bus_nh.if_valid = bus.if_valid;
    assign bus_nb.if_instr = bus.if_instr;  assign bus_nh.if_instr = bus.if_instr;
    assign bus_nb.if_pc2   = bus.if_pc2;    assign bus_nh.if_pc2   = bus.if_pc2;
    assign bus_nb.ex_ready = bus.ex_ready;  assign bus_nh.ex_ready = bus.ex_ready;
    assign bus_nb.flush    = bus.flush;     assign bus_nh.flush    = bus.flush;
    assign bus_nb.wb_en    = bus.wb_en;     assign bus_nh.wb_en    = bus.wb_en;
    assign bus_nb.wb_reg   = bus.wb_reg;    assign bus_nh.wb_reg   = bus.wb_reg;
    assign bus_nb.wb_data  = bus.wb_data;   assign bus_nh.wb_data  = bus.wb_data;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] rd1, rd2, imm5, imm8, imm11;
        logic [2:0]  wreg;
        logic        wen;
        logic [4:0]  flags;   // {MemEn, MemWr, Branch, Jump, sign}
    } vec_t;

    vec_t vecs [9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] instr);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc2   = bus.if_pc2 + 16'd2;
    endtask

    function automatic logic [4:0] flags_of(input logic [21:0] c);
        return {c[9], c[8], c[7], c[6], c[1]};
    endfunction

    initial begin
        vecs[0] = '{16'hDB44, 16'h3333, 16'h2222, 16'h0004, 16'h0044, 16'h0344, 3'd1, 1'b1, 5'b00001};
        vecs[1] = '{16'h413F, 16'h1111, 16'h1111, 16'hFFFF, 16'h003F, 16'h013F, 3'd1, 1'b1, 5'b00001};
        vecs[2] = '{16'h553F, 16'h5555, 16'h1111, 16'h001F, 16'h003F, 16'h053F, 3'd1, 1'b1, 5'b00000};
        vecs[3] = '{16'h86E0, 16'h6666, 16'h7777, 16'h0000, 16'hFFE0, 16'hFEE0, 3'd0, 1'b0, 5'b11001};
        vecs[4] = '{16'h3FFF, 16'h7777, 16'h7777, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7, 1'b1, 5'b00011};
        vecs[5] = '{16'hC0FF, 16'h0F0F, 16'h7777, 16'hFFFF, 16'hFFFF, 16'h00FF, 3'd0, 1'b1, 5'b00001};
        vecs[6] = '{16'h9480, 16'h4444, 16'h4444, 16'h0000, 16'h0080, 16'h0480, 3'd4, 1'b1, 5'b00000};
        vecs[7] = '{16'h8A20, 16'h2222, 16'h1111, 16'h0000, 16'h0020, 16'h0220, 3'd1, 1'b1, 5'b10001};
        vecs[8] = '{16'h6A80, 16'h2222, 16'h4444, 16'h0000, 16'hFF80, 16'h0280, 3'd0, 1'b0, 5'b00101};

        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc2 = 16'h0100;
        bus.ex_ready = 1'b1; bus.flush = 1'b0;
        bus.wb_en = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;

        // Power-on reset
        tick(); tick();
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_halt", bus.id_halt, 0);
        chk("rst_id_instr", bus.id_instr, 0);
        rst = 1'b1;
        #1;
        chk("rst_if_ready", bus.if_ready, 1);

        // Preload r0 = 0x0F0F, rk = k * 0x1111
        for (int k = 0; k < 8; k++) begin
            bus.wb_en   = 1'b1;
            bus.wb_reg  = 3'(k);
            bus.wb_data = (k == 0) ? 16'h0F0F : 16'(k * 16'h1111);
            tick();
        end
        bus.wb_en = 1'b0;

        // Vector table, one accept per cycle
        for (int i = 0; i < 9; i++) begin
            offer(vecs[i].instr);
            #1;
            chk($sformatf("v%0d_if_ready", i), bus.if_ready, 1);
            tick();
            chk($sformatf("v%0d_valid", i), bus.id_valid, 1);
            chk($sformatf("v%0d_instr", i), bus.id_instr, vecs[i].instr);
            chk($sformatf("v%0d_pc2", i), bus.id_pc2, bus.if_pc2);
            chk($sformatf("v%0d_rdata1", i), bus.id_rdata1, vecs[i].rd1);
            chk($sformatf("v%0d_rdata2", i), bus.id_rdata2, vecs[i].rd2);
            chk($sformatf("v%0d_imm5", i), bus.id_imm5, vecs[i].imm5);
            chk($sformatf("v%0d_imm8", i), bus.id_imm8, vecs[i].imm8);
            chk($sformatf("v%0d_imm11", i), bus.id_imm11, vecs[i].imm11);
            chk($sformatf("v%0d_wreg", i), bus.id_wreg, vecs[i].wreg);
            chk($sformatf("v%0d_wen", i), bus.id_wen, vecs[i].wen);
            chk($sformatf("v%0d_flags", i), flags_of(bus.id_ctrl), vecs[i].flags);
        end

        // Same-cycle writeback bypass of r3
        offer(16'hDB44);
        bus.wb_en = 1'b1; bus.wb_reg = 3'd3; bus.wb_data = 16'h1234;
        tick();
        bus.wb_en = 1'b0;
        chk("byp_rdata1", bus.id_rdata1, 16'h1234);
        chk("byp_wreg", bus.id_wreg, 1);
        chk("nobyp_rdata1", bus_nb.id_rdata1, 16'h3333);
        tick();
        chk("nobyp_next_rdata1", bus_nb.id_rdata1, 16'h1234);

        // Load-use with ex_ready high: one bubble
        offer(16'h8A20);
        tick();
        offer(16'hD92C);
        #1;
        chk("lu_if_ready", bus.if_ready, 0);
        chk("nohz_if_ready", bus_nh.if_ready, 1);
        tick();
        chk("lu_bubble", bus.id_valid, 0);
        chk("nohz_valid", bus_nh.id_valid, 1);
        chk("nohz_instr", bus_nh.id_instr, 16'hD92C);
        #1;
        chk("lu_if_ready2", bus.if_ready, 1);
        tick();
        chk("lu_valid", bus.id_valid, 1);
        chk("lu_instr", bus.id_instr, 16'hD92C);
        chk("lu_wreg", bus.id_wreg, 3);

        // Load-use while execute stalls: load held, stall lasts
        offer(16'h8A20);
        tick();
        bus.ex_ready = 1'b0;
        offer(16'hD92C);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("lus_if_ready%0d", c), bus.if_ready, 0);
            tick();
            chk($sformatf("lus_instr%0d", c), bus.id_instr, 16'h8A20);
            chk($sformatf("lus_valid%0d", c), bus.id_valid, 1);
        end
        bus.ex_ready = 1'b1;
        tick();
        chk("lus_bubble", bus.id_valid, 0);
        tick();
        chk("lus_instr", bus.id_instr, 16'hD92C);

        // Backpressure: outputs frozen while the register file still updates
        bus.ex_ready = 1'b0;
        offer(16'h4125);
        bus.wb_en = 1'b1; bus.wb_reg = 3'd1; bus.wb_data = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_if_ready%0d", c), bus.if_ready, 0);
            tick();
            bus.wb_en = 1'b0;
            chk($sformatf("bp_valid%0d", c), bus.id_valid, 1);
            chk($sformatf("bp_instr%0d", c), bus.id_instr, 16'hD92C);
            chk($sformatf("bp_rdata1_%0d", c), bus.id_rdata1, 16'h1111);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("bp_release_if_ready", bus.if_ready, 1);
        tick();
        chk("bp_instr", bus.id_instr, 16'h4125);
        chk("bp_imm5", bus.id_imm5, 16'h0005);
        chk("bp_rdata1", bus.id_rdata1, 16'hBEEF);

        // Flush beats accept
        bus.flush = 1'b1;
        offer(16'hDB44);
        #1;
        chk("fl_if_ready", bus.if_ready, 0);
        tick();
        bus.flush = 1'b0;
        chk("fl_valid", bus.id_valid, 0);
        chk("fl_instr_held", bus.id_instr, 16'h4125);

        // Asynchronous reset mid-stream
        offer(16'hDB44);
        tick();
        chk("mr_pre_valid", bus.id_valid, 1);
        rst = 1'b0;
        #1;
        chk("mr_valid", bus.id_valid, 0);
        chk("mr_instr", bus.id_instr, 0);
        chk("mr_rdata1", bus.id_rdata1, 0);
        chk("mr_ctrl", bus.id_ctrl, 0);
        chk("mr_halt", bus.id_halt, 0);
        tick();
        rst = 1'b1;
        bus.if_valid = 1'b0;
        #1;
        chk("mr_if_ready", bus.if_ready, 1);
        for (int k = 0; k < 8; k++) begin
            offer(16'h0800 | 16'(k << 8) | 16'(k << 5));
            tick();
            chk($sformatf("zero_r%0d_a", k), bus.id_rdata1, 0);
            chk($sformatf("zero_r%0d_b", k), bus.id_rdata2, 0);
        end

        // Sticky halt
        offer(16'h0000);
        #1;
        chk("h_if_ready", bus.if_ready, 1);
        tick();
        chk("h_halt", bus.id_halt, 1);
        chk("h_valid", bus.id_valid, 1);
        offer(16'hDB44);
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("h_if_ready%0d", c), bus.if_ready, 0);
            tick();
            chk($sformatf("h_drain%0d", c), bus.id_valid, 0);
        end
        rst = 1'b0;
        #1;
        chk("h_rst_halt", bus.id_halt, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("h_rst_if_ready", bus.if_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
